// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle one-bit-per-clock shift/rotate unit
module iter_shifter #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_SRA  = 2'b10;
   localparam logic [1:0] OP_ROTR = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_sh;
   logic [SHW-1:0]   cnt;
   logic [1:0]       op_r;

   // State register; reset abandons any operation in flight without a done pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode; start is only looked at in IDLE so it is never queued
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = (b == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == SHW'(1)) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // One-bit step of the accumulator for the latched operation
   always_comb begin
      acc_sh = acc;
      case (op_r)
         OP_SLL:  acc_sh = {acc[WIDTH-2:0], 1'b0};
         OP_SRL:  acc_sh = {1'b0, acc[WIDTH-1:1]};
         OP_SRA:  acc_sh = {acc[WIDTH-1], acc[WIDTH-1:1]};
         OP_ROTR: acc_sh = {acc[0], acc[WIDTH-1:1]};
         default: acc_sh = acc;
      endcase
   end

   // Datapath: operands captured at accept, result updated only when entering DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc    <= '0;
         cnt    <= '0;
         op_r   <= OP_SLL;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc  <= a;
                  cnt  <= b;
                  op_r <= op;
                  if (b == '0) begin
                     result <= a;
                  end
               end
            end
            SHIFT: begin
               acc <= acc_sh;
               cnt <= cnt - SHW'(1);
               if (cnt == SHW'(1)) begin
                  result <= acc_sh;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule
